sideband_collector: RTL
=======================

// Module: sideband_collector
// PURPOSE
//  Per-frame metadata collector, parametrised successor of the single-check sideband stage. Gathers
//  NUM_CHECKS filter verdicts plus one destination per frame; commits {wptr,dest} record to a sync FIFO
//  on frame acceptance, else raises frame_drop. Sits between filter checkers and the frame-buffer reader.
//  Adds per-reason saturating statistics and FIFO-full drop policy.
// PARAMETERS
//  ADDR_WIDTH       11  frame-buffer address width; wptr carries ADDR_WIDTH+1 bits (wrap bit)
//  DEST_WIDTH       2   destination field width
//  NUM_CHECKS       4   number of independent drop-verdict sources
//  FIFO_ADDR_WIDTH  9   record FIFO depth = 2**FIFO_ADDR_WIDTH
//  CNT_WIDTH        16  statistics counter width
// PORTS
//  clk           in   1                    clock
//  reset         in   1                    sync, active-high
//  scan_frame    in   1                    high for the whole duration of a frame scan
//  chk_valid     in   NUM_CHECKS           verdict strobe per check
//  chk_drop      in   NUM_CHECKS           verdict value (1=drop), qualified by chk_valid
//  dest_valid    in   1                    destination strobe
//  dest_drop     in   1                    destination lookup failed
//  dest_data     in   DEST_WIDTH           destination
//  frame_wptr    in   ADDR_WIDTH+1         frame-buffer write pointer (frame start when sampled)
//  frame_drop    out  1                    current frame must be discarded
//  ren           in   1                    record pop
//  rdata         out  REC_W                record {wptr, dest}, REC_W=ADDR_WIDTH+1+DEST_WIDTH
//  empty         out  1                    no record available
//  full          out  1                    record FIFO full
//  clr_stats     in   1                    sync clear of all counters
//  accept_cnt    out  CNT_WIDTH            frames committed
//  drop_cnt      out  CNT_WIDTH            frames dropped by a check or dest
//  ovf_cnt       out  CNT_WIDTH            frames dropped due to FIFO full
//  incomplete_cnt out CNT_WIDTH            frames ended before all fields valid
// BEHAVIOUR
//  Reset: state IDLE, frame_drop=0, empty=1, wen=0, field mask=0, all counters=0, FIFO pointers cleared.
//  IDLE (scan_frame=0): wptr_q<=frame_wptr every cycle; mask, dest_q, frame_drop cleared. scan_frame=1 -> SCAN.
//  SCAN: chk_valid[i] sets mask[i]; dest_valid captures dest_data, sets mask[NUM_CHECKS]. wptr_q frozen.
//   Any valid&drop (check or dest) -> frame_drop=1 next cycle, drop_cnt++, -> DONE. Drop beats valid same cycle.
//   mask all-ones & no drop -> COMMIT next cycle.
//   scan_frame=0 before mask complete -> incomplete_cnt++, frame_drop=1 for one cycle, -> IDLE.
//  COMMIT (one cycle): if ~full: wen=1 exactly this cycle, accept_cnt++; else frame_drop=1, ovf_cnt++.
//   -> DONE. Exactly one write per frame, never on a dropped frame.
//  DONE: ignore further strobes; frame_drop held; scan_frame=0 -> IDLE (frame_drop clears next cycle).
//  scan_frame falling while in COMMIT: commit completes, then IDLE.
//  empty = fifo_empty | prev_reset, registered (one-cycle delay after reset deassert and after write).
//  ren while empty ignored by FIFO; simultaneous ren/wen when full at COMMIT still counts overflow.
//  Counters saturate at all-ones; clr_stats wins over same-cycle increment.
//  Reset mid-frame: aborts frame, no record, no counter update.
// STRUCTURE
//  filter_defs package: sc_state_t {IDLE,SCAN,COMMIT,DONE}; sc_record_t packed struct {wptr,dest};
//   saturating-increment function.
//  Sub-module: fifo_sync (W_EL=REC_W, ADDR_WIDTH=FIFO_ADDR_WIDTH, CAN_RESET_POINTERS=0).
// TESTING
//  1 All 4 checks pass, dest=2, wptr=0x105 -> one record 0x105/2 after COMMIT, empty falls next cycle, accept_cnt=1.
//  2 chk_drop[2]=1 with chk_valid[2] -> frame_drop=1 next cycle until scan_frame low, drop_cnt=1, no record.
//  3 Fill FIFO with 512 frames, 513th passes -> frame_drop=1, ovf_cnt=1, FIFO contents unchanged.
//  4 scan_frame falls with mask=0b0111 -> incomplete_cnt=1, no write; next frame commits normally.
//  5 reset pulse during SCAN -> empty=1, counters 0, following frame wptr=0x7FF writes 0x7FF record.
//  6 drop_cnt at 0xFFFF plus drop -> stays 0xFFFF; clr_stats with increment same cycle -> 0.

Source files
------------

// File: rtl/filter_defs.sv
// Shared types and helpers for the sideband metadata collector.
// Record layout and state encoding used by the collector and its readers.
package filter_defs;

   localparam int unsigned SC_ADDR_WIDTH = 11;
   localparam int unsigned SC_DEST_WIDTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT,
      DONE
   } sc_state_t;

   typedef struct packed {
      logic [SC_ADDR_WIDTH:0]   wptr;
      logic [SC_DEST_WIDTH-1:0] dest;
   } sc_record_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : value + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; rdata presents the head entry whenever empty is low.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
module fifo_sync #(
   parameter int unsigned W_EL               = 8,
   parameter int unsigned ADDR_WIDTH         = 4,
   parameter int unsigned CAN_RESET_POINTERS = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            wen,
   input  logic [W_EL-1:0] wdata,
   input  logic            ren,
   output logic [W_EL-1:0] rdata,
   output logic            empty,
   output logic            full
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [W_EL-1:0]     mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                flush_en;
   logic                do_write;
   logic                do_read;

   // flush only takes effect on builds that allow a pointer-only clear
   assign flush_en = (CAN_RESET_POINTERS != 0) && flush;
   assign do_write = wen && !full;
   assign do_read  = ren && !empty;

   always_ff @(posedge clk) begin
      if (reset || flush_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[ADDR_WIDTH-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

endmodule

// File: rtl/sideband_collector.sv
// Per-frame metadata collector: gathers check verdicts and a destination, then commits
// one {wptr,dest} record per accepted frame into a FIFO, with saturating drop statistics.
module sideband_collector
   import filter_defs::*;
#(
   parameter int unsigned ADDR_WIDTH      = 11,
   parameter int unsigned DEST_WIDTH      = 2,
   parameter int unsigned NUM_CHECKS      = 4,
   parameter int unsigned FIFO_ADDR_WIDTH = 9,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           scan_frame,
   input  logic [NUM_CHECKS-1:0]          chk_valid,
   input  logic [NUM_CHECKS-1:0]          chk_drop,
   input  logic                           dest_valid,
   input  logic                           dest_drop,
   input  logic [DEST_WIDTH-1:0]          dest_data,
   input  logic [ADDR_WIDTH:0]            frame_wptr,
   output logic                           frame_drop,
   input  logic                           ren,
   output logic [ADDR_WIDTH+DEST_WIDTH:0] rdata,
   output logic                           empty,
   output logic                           full,
   input  logic                           clr_stats,
   output logic [CNT_WIDTH-1:0]           accept_cnt,
   output logic [CNT_WIDTH-1:0]           drop_cnt,
   output logic [CNT_WIDTH-1:0]           ovf_cnt,
   output logic [CNT_WIDTH-1:0]           incomplete_cnt
);

   localparam int unsigned REC_W  = ADDR_WIDTH + 1 + DEST_WIDTH;
   localparam int unsigned MASK_W = NUM_CHECKS + 1;

   sc_state_t             state;
   sc_state_t             state_nxt;
   logic [ADDR_WIDTH:0]   wptr_q;
   logic [DEST_WIDTH-1:0] dest_q;
   logic [MASK_W-1:0]     mask;
   logic [MASK_W-1:0]     new_mask;
   logic                  any_drop;
   logic                  mask_done;
   logic                  reset_q;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_ren;
   logic [REC_W-1:0]      fifo_wdata;
   logic                  wen;
   logic                  inc_accept;
   logic                  inc_drop;
   logic                  inc_ovf;
   logic                  inc_incomplete;

   assign new_mask  = mask | {dest_valid, chk_valid};
   assign mask_done = &new_mask;
   assign any_drop  = (|(chk_valid & chk_drop)) || (dest_valid && dest_drop);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // A drop in the same cycle as the completing strobe wins over commit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (scan_frame) state_nxt = SCAN;
         SCAN: begin
            if (any_drop)        state_nxt = DONE;
            else if (mask_done)  state_nxt = COMMIT;
            else if (!scan_frame) state_nxt = IDLE;
         end
         COMMIT:  state_nxt = scan_frame ? DONE : IDLE;
         DONE:    if (!scan_frame) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wen            = 1'b0;
      inc_accept     = 1'b0;
      inc_drop       = 1'b0;
      inc_ovf        = 1'b0;
      inc_incomplete = 1'b0;
      case (state)
         SCAN: begin
            inc_drop       = any_drop;
            inc_incomplete = !any_drop && !mask_done && !scan_frame;
         end
         COMMIT: begin
            wen        = !fifo_full;
            inc_accept = !fifo_full;
            inc_ovf    = fifo_full;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         dest_q     <= '0;
         mask       <= '0;
         frame_drop <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wptr_q     <= frame_wptr;
               dest_q     <= '0;
               mask       <= '0;
               frame_drop <= 1'b0;
            end
            SCAN: begin
               mask <= new_mask;
               if (dest_valid) dest_q <= dest_data;
               if (inc_drop || inc_incomplete) frame_drop <= 1'b1;
            end
            COMMIT:  if (inc_ovf) frame_drop <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr_stats) begin
         accept_cnt     <= '0;
         drop_cnt       <= '0;
         ovf_cnt        <= '0;
         incomplete_cnt <= '0;
      end else begin
         if (inc_accept)     accept_cnt     <= CNT_WIDTH'(sat_inc(32'(accept_cnt), CNT_WIDTH));
         if (inc_drop)       drop_cnt       <= CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_WIDTH));
         if (inc_ovf)        ovf_cnt        <= CNT_WIDTH'(sat_inc(32'(ovf_cnt), CNT_WIDTH));
         if (inc_incomplete) incomplete_cnt <= CNT_WIDTH'(sat_inc(32'(incomplete_cnt), CNT_WIDTH));
      end
   end

   // empty lags the FIFO by a cycle and stays high for one cycle after reset release
   always_ff @(posedge clk) begin
      reset_q <= reset;
      if (reset) empty <= 1'b1;
      else       empty <= fifo_empty || reset_q;
   end

   assign fifo_ren   = ren && !empty;
   assign fifo_wdata = {wptr_q, dest_q};
   assign full       = fifo_full;

   fifo_sync #(
      .W_EL              (REC_W),
      .ADDR_WIDTH        (FIFO_ADDR_WIDTH),
      .CAN_RESET_POINTERS(0)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .flush(1'b0),
      .wen  (wen),
      .wdata(fifo_wdata),
      .ren  (fifo_ren),
      .rdata(rdata),
      .empty(fifo_empty),
      .full (fifo_full)
   );

endmodule
